// File: rtl/gpu_pixel_writer.sv
// rtl/gpu_pixel_writer.sv - clips, addresses and queues fill_rect pixels, drains them to framebuffer SRAM
module gpu_pixel_writer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int WIDTH_BITS    = 10,
    parameter int HEIGHT_BITS   = 9,
    parameter int ADDR_BITS     = 20,
    parameter int COLOR_BITS    = 32,
    parameter int DEPTH         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pixel_valid_i,
    input  logic [WIDTH_BITS-1:0]  x_i,
    input  logic [HEIGHT_BITS-1:0] y_i,
    input  logic [COLOR_BITS-1:0]  color_i,
    input  logic [ADDR_BITS-1:0]   base_addr_i,
    input  logic                   done_i,
    output logic                   ready_o,
    output logic                   mem_req_o,
    output logic [ADDR_BITS-1:0]   mem_addr_o,
    output logic [COLOR_BITS-1:0]  mem_data_o,
    input  logic                   mem_ack_i,
    output logic                   done_o,
    output logic                   overflow_o,
    output logic                   clipped_o
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

    state_t r_state, w_state_next;

    logic                  r_s1_valid;
    logic                  r_s1_clip;
    logic [ADDR_BITS-1:0]  r_s1_addr;
    logic [COLOR_BITS-1:0] r_s1_color;

    logic [ADDR_BITS-1:0]  r_fifo_addr [DEPTH];
    logic [COLOR_BITS-1:0] r_fifo_data [DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [CNT_BITS-1:0]   r_count;
    logic                  r_overflow;
    logic                  r_clipped;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_clip;
    logic [ADDR_BITS-1:0]  w_addr;

    // One FIFO slot stays free for the pixel that may already sit in stage 1.
    assign ready_o  = (r_count < CNT_BITS'(DEPTH - 1));
    assign w_accept = pixel_valid_i & ready_o;
    assign w_push   = r_s1_valid & ~r_s1_clip;
    assign w_pop    = (r_count != '0) & mem_ack_i;

    assign w_addr = base_addr_i
                  + ADDR_BITS'(y_i) * ADDR_BITS'(SCREEN_WIDTH)
                  + ADDR_BITS'(x_i);
    assign w_clip = ({{(32-WIDTH_BITS){1'b0}}, x_i} >= 32'(SCREEN_WIDTH))
                  | ({{(32-HEIGHT_BITS){1'b0}}, y_i} >= 32'(SCREEN_HEIGHT));

    assign mem_req_o  = (r_count != '0);
    assign mem_addr_o = mem_req_o ? r_fifo_addr[r_rd_ptr] : '0;
    assign mem_data_o = mem_req_o ? r_fifo_data[r_rd_ptr] : '0;
    assign done_o     = (r_state == S_DONE);
    assign overflow_o = r_overflow;
    assign clipped_o  = r_clipped;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_clip  <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_color <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_clip  <= w_clip;
                r_s1_addr  <= w_addr;
                r_s1_color <= color_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_s1_addr;
            r_fifo_data[r_wr_ptr] <= r_s1_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_clipped  <= 1'b0;
        end else begin
            if (pixel_valid_i & ~ready_o) r_overflow <= 1'b1;
            if (r_s1_valid & r_s1_clip)   r_clipped  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // DRAIN ends once nothing is in flight after this edge, counting a final pop.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (done_i)        w_state_next = S_DRAIN;
                else if (w_accept) w_state_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (done_i) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_s1_valid && !w_accept &&
                    ((r_count == '0) || ((r_count == CNT_BITS'(1)) && w_pop)))
                    w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_gpu_pixel_writer.sv
// tb/tb_gpu_pixel_writer.sv - scoreboard bench for gpu_pixel_writer
module tb_gpu_pixel_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_valid_i = 1'b0;
    logic [9:0]  x_i = '0;
    logic [8:0]  y_i = '0;
    logic [31:0] color_i = '0;
    logic [19:0] base_addr_i = '0;
    logic        done_i = 1'b0;
    logic        ready_o;
    logic        mem_req_o;
    logic [19:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_ack_i = 1'b0;
    logic        done_o;
    logic        overflow_o;
    logic        clipped_o;

    gpu_pixel_writer dut (
        .clk(clk), .rst(rst), .pixel_valid_i(pixel_valid_i), .x_i(x_i), .y_i(y_i),
        .color_i(color_i), .base_addr_i(base_addr_i), .done_i(done_i), .ready_o(ready_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .done_o(done_o), .overflow_o(overflow_o), .clipped_o(clipped_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    int          n_writes = 0;
    int          n_done = 0;
    logic [19:0] last_addr = '0;

    // Reference: pixels in flight as a one-deep holding slot plus a FIFO occupancy.
    int          m_cnt = 0;
    bit          m_s1_v = 0;
    bit          m_s1_clip = 0;
    logic [19:0] m_s1_a = '0;
    logic [31:0] m_s1_d = '0;
    bit          m_ovf = 0;
    bit          m_clip = 0;
    bit          m_done_pend = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit acc, push, pop;
        if (!rst) begin
            chk("ready_o", ready_o, m_cnt < 7);
            chk("mem_req_o", mem_req_o, m_cnt > 0);
            chk("overflow_o", overflow_o, m_ovf);
            chk("clipped_o", clipped_o, m_clip);
            if (done_o) begin
                n_done++;
                chk("done_expected", m_done_pend, 1);
                chk("done_drained", sb.size() + m_cnt + int'(m_s1_v), 0);
                m_done_pend = 0;
            end
        end
        if (rst) begin
            sb.delete();
            m_cnt = 0; m_s1_v = 0; m_ovf = 0; m_clip = 0; m_done_pend = 0;
        end else begin
            acc  = pixel_valid_i && (m_cnt < 7);
            pop  = (m_cnt > 0) && mem_ack_i;
            push = m_s1_v && !m_s1_clip;
            if (pixel_valid_i && !acc) m_ovf = 1;
            if (m_s1_v && m_s1_clip) m_clip = 1;
            if (push) sb.push_back('{a: m_s1_a, d: m_s1_d});
            m_cnt = m_cnt + int'(push) - int'(pop);
            m_s1_v = acc;
            if (acc) begin
                m_s1_clip = (int'(x_i) >= 640) || (int'(y_i) >= 480);
                m_s1_a = 20'((int'(base_addr_i) + int'(y_i) * 640 + int'(x_i)) % (1 << 20));
                m_s1_d = color_i;
            end
            if (done_i && !m_done_pend) m_done_pend = 1;
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (!rst && mem_req_o && mem_ack_i) begin
            n_writes++;
            last_addr = mem_addr_o;
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("write_addr", mem_addr_o, e.a);
                chk("write_data", mem_data_o, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input logic [31:0] c, input int b);
        pixel_valid_i = 1'b1;
        x_i = 10'(x); y_i = 9'(y); color_i = c; base_addr_i = 20'(b);
        tick();
        pixel_valid_i = 1'b0;
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (m_done_pend && n < limit) begin
            tick();
            n++;
        end
        if (m_done_pend) chk("done_timeout", 1, 0);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready", ready_o, 1);
        chk("rst_req", mem_req_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_data", mem_data_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_clip", clipped_o, 0);

        // single pixel, latency N+2
        mem_ack_i = 1'b1;
        d0 = n_done;
        send(3, 2, 32'hFF00FF00, 0);
        chk("single_req_n1", mem_req_o, 0);
        pulse_done();
        chk("single_req_n2", mem_req_o, 1);
        chk("single_addr", mem_addr_o, 1283);
        chk("single_data", mem_data_o, 32'hFF00FF00);
        wait_done(50);
        repeat (3) tick();
        chk("single_done_count", n_done, d0 + 1);

        // base offset wraps silently
        send(1, 0, 32'h12345678, 20'hFFFFF);
        tick();
        chk("wrap_addr", mem_addr_o, 0);
        pulse_done();
        wait_done(50);

        // clipping
        w0 = n_writes; d0 = n_done;
        send(640, 0, 32'hA, 0);
        send(639, 479, 32'hB, 0);
        send(0, 480, 32'hC, 0);
        pulse_done();
        wait_done(50);
        chk("clip_writes", n_writes, w0 + 1);
        chk("clip_addr", last_addr, 307199);
        chk("clip_sticky", clipped_o, 1);
        chk("clip_done", n_done, d0 + 1);

        // backpressure
        mem_ack_i = 1'b0;
        pixel_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            x_i = 10'(i * 7); y_i = 9'(i); color_i = $urandom; base_addr_i = 20'(i * 100);
            tick();
        end
        pixel_valid_i = 1'b0;
        chk("bp_ready_low", ready_o, 0);
        chk("bp_overflow", overflow_o, 1);
        mem_ack_i = 1'b1;
        pulse_done();
        wait_done(100);

        // reset mid-drain
        mem_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) send(i, 10, 32'h100 + 32'(i), 0);
        tick();
        d0 = n_done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_req", mem_req_o, 0);
        chk("rstmid_ready", ready_o, 1);
        repeat (5) tick();
        chk("rstmid_no_done", n_done, d0);
        mem_ack_i = 1'b1;
        w0 = n_writes;
        send(5, 5, 32'hCAFEF00D, 0);
        pulse_done();
        wait_done(50);
        chk("rstmid_new_write", n_writes, w0 + 1);

        // rectangle stream
        w0 = n_writes;
        pixel_valid_i = 1'b1;
        color_i = 32'h00C0FFEE; base_addr_i = '0;
        for (int y = 0; y <= 150; y++) begin
            for (int x = 0; x <= 200; x++) begin
                x_i = 10'(x); y_i = 9'(y);
                tick();
            end
        end
        pixel_valid_i = 1'b0;
        pulse_done();
        wait_done(100);
        chk("rect_writes", n_writes, w0 + 30351);
        chk("rect_ovf", overflow_o, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            pixel_valid_i = ($urandom_range(0, 9) < 7);
            x_i = 10'($urandom_range(0, 700));
            y_i = 9'($urandom_range(0, 511));
            color_i = $urandom;
            base_addr_i = 20'($urandom);
            mem_ack_i = $urandom_range(0, 1);
            tick();
        end
        pixel_valid_i = 1'b0;
        mem_ack_i = 1'b1;
        pulse_done();
        wait_done(100);
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
